// File: rtl/sid_voice_pipe.sv
// Time-multiplexed SID voice DCA: per-voice waveform-0 hold with TTL fade,
// model-dependent DC offsets and a two-stage waveform x envelope multiply-add.

package sid;
    typedef enum logic {
        MOS6581 = 1'b0,
        MOS8580 = 1'b1
    } model_e;
endpackage

module sid_voice_pipe #(
    parameter int  VOICES        = 3,
    parameter int  WAVE_BITS     = 12,
    parameter int  ENV_BITS      = 8,
    parameter int  TTL_BITS      = 23,
    parameter int  WF0_TTL_6581  = 200000,
    parameter int  WF0_TTL_8580  = 5000000,
    parameter int  FADE_MODE     = 0,
    parameter int  WAVE_DC_6581  = -896,
    parameter int  WAVE_DC_8580  = -(1 << (WAVE_BITS - 1)),
    parameter int  VOICE_DC_6581 = (1 << (WAVE_BITS - 1)) * ((1 << ENV_BITS) - 1),
    localparam int VB            = (VOICES > 1) ? $clog2(VOICES) : 1,
    localparam int OW            = WAVE_BITS + ENV_BITS + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  sid::model_e          model,
    input  logic                 in_valid,
    input  logic [WAVE_BITS-1:0] wave_i,
    input  logic                 wave_none_i,
    input  logic [ENV_BITS-1:0]  env_i,
    output logic                 out_valid,
    output logic [VB-1:0]        out_voice,
    output logic                 frame_o,
    output logic signed [OW-1:0] voice_o,
    output logic [7:0]           osc_o
);

    localparam logic [TTL_BITS-1:0] TTL_6581   = TTL_BITS'(WF0_TTL_6581);
    localparam logic [TTL_BITS-1:0] TTL_8580   = TTL_BITS'(WF0_TTL_8580);
    localparam logic [VB-1:0]       LAST_VOICE = VB'(VOICES - 1);

    // ------------------------------------------------------------------
    // Slot counter and per-voice hold state
    // ------------------------------------------------------------------
    logic [VB-1:0]                          slot_q, slot_d;
    logic [TTL_BITS-1:0]                    ttl;
    logic [VOICES-1:0][WAVE_BITS-1:0]       held_all;
    logic [WAVE_BITS-1:0]                   eff_d;

    always_comb begin
        ttl   = (model == sid::MOS6581) ? TTL_6581 : TTL_8580;
        slot_d = slot_q;
        if (in_valid) begin
            slot_d = (slot_q == LAST_VOICE) ? '0 : slot_q + 1'b1;
        end
        // A held voice replays its pre-update value in the slot that fades it.
        eff_d = wave_none_i ? held_all[slot_q] : wave_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_voice
            logic [WAVE_BITS-1:0] held_q, held_d;
            logic [TTL_BITS-1:0]  age_q, age_d;
            logic                 hit;

            assign hit = in_valid && (slot_q == VB'(gi));

            always_comb begin
                held_d = held_q;
                age_d  = age_q;
                if (hit) begin
                    if (!wave_none_i) begin
                        held_d = wave_i;
                        age_d  = '0;
                    end else if (age_q >= ttl) begin
                        // ">=" also catches an age left above a smaller TTL by a model switch.
                        age_d  = ttl;
                        held_d = (FADE_MODE != 0) ? (held_q >> 1) : '0;
                    end else begin
                        age_d  = age_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    held_q <= '0;
                    age_q  <= '0;
                end else begin
                    held_q <= held_d;
                    age_q  <= age_d;
                end
            end

            assign held_all[gi] = held_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: effective waveform, envelope, model and voice index
    // ------------------------------------------------------------------
    logic                 s1_valid_q, s1_valid_d;
    logic [WAVE_BITS-1:0] s1_eff_q, s1_eff_d;
    logic [ENV_BITS-1:0]  s1_env_q, s1_env_d;
    sid::model_e          s1_model_q, s1_model_d;
    logic [VB-1:0]        s1_voice_q, s1_voice_d;

    always_comb begin
        s1_valid_d = in_valid;
        s1_eff_d   = s1_eff_q;
        s1_env_d   = s1_env_q;
        s1_model_d = s1_model_q;
        s1_voice_d = s1_voice_q;
        if (in_valid) begin
            s1_eff_d   = eff_d;
            s1_env_d   = env_i;
            s1_model_d = model;
            s1_voice_d = slot_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_eff_q   <= '0;
            s1_env_q   <= '0;
            s1_model_q <= sid::MOS6581;
            s1_voice_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_eff_q   <= s1_eff_d;
            s1_env_q   <= s1_env_d;
            s1_model_q <= s1_model_d;
            s1_voice_q <= s1_voice_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: (eff + WAVE_DC) * env at 32 bits
    // ------------------------------------------------------------------
    logic               s2_valid_q, s2_valid_d;
    logic signed [31:0] s2_prod_q, s2_prod_d;
    sid::model_e        s2_model_q, s2_model_d;
    logic [7:0]         s2_osc_q, s2_osc_d;
    logic [VB-1:0]      s2_voice_q, s2_voice_d;
    logic               s2_frame_q, s2_frame_d;
    logic signed [31:0] eff_s, env_s, wave_dc;

    always_comb begin
        eff_s      = signed'(32'(s1_eff_q));
        env_s      = signed'(32'(s1_env_q));
        wave_dc    = (s1_model_q == sid::MOS6581) ? 32'(WAVE_DC_6581) : 32'(WAVE_DC_8580);
        s2_valid_d = s1_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_model_d = s2_model_q;
        s2_osc_d   = s2_osc_q;
        s2_voice_d = s2_voice_q;
        s2_frame_d = s2_frame_q;
        if (s1_valid_q) begin
            s2_prod_d  = (eff_s + wave_dc) * env_s;
            s2_model_d = s1_model_q;
            s2_osc_d   = s1_eff_q[WAVE_BITS-1 -: 8];
            s2_voice_d = s1_voice_q;
            s2_frame_d = (s1_voice_q == LAST_VOICE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_model_q <= sid::MOS6581;
            s2_osc_q   <= '0;
            s2_voice_q <= '0;
            s2_frame_q <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_model_q <= s2_model_d;
            s2_osc_q   <= s2_osc_d;
            s2_voice_q <= s2_voice_d;
            s2_frame_q <= s2_frame_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register: add the model's output offset and truncate
    // ------------------------------------------------------------------
    logic                 out_valid_q, out_valid_d;
    logic [VB-1:0]        out_voice_q, out_voice_d;
    logic                 frame_q, frame_d;
    logic signed [OW-1:0] voice_q, voice_d;
    logic [7:0]           osc_q, osc_d;
    logic signed [31:0]   voice_dc;

    always_comb begin
        voice_dc    = (s2_model_q == sid::MOS6581) ? 32'(VOICE_DC_6581) : '0;
        out_valid_d = s2_valid_q;
        out_voice_d = out_voice_q;
        frame_d     = frame_q;
        voice_d     = voice_q;
        osc_d       = osc_q;
        if (s2_valid_q) begin
            out_voice_d = s2_voice_q;
            frame_d     = s2_frame_q;
            voice_d     = OW'(voice_dc + s2_prod_q);
            osc_d       = s2_osc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_voice_q <= '0;
            frame_q     <= 1'b0;
            voice_q     <= '0;
            osc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_voice_q <= out_voice_d;
            frame_q     <= frame_d;
            voice_q     <= voice_d;
            osc_q       <= osc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_voice = out_voice_q;
    assign frame_o   = frame_q;
    assign voice_o   = voice_q;
    assign osc_o     = osc_q;

endmodule
